branch_cond_unit: RTL

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

---
 rtl/branch_cond_unit_pkg.sv | 41 ++++
 rtl/branch_cond_unit_cond_eval.sv | 35 +++
 rtl/branch_cond_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/branch_cond_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_pkg
//   Shared types and constants for the branch condition unit and anything that
//   needs to decode the same condition codes (e.g. the instruction decoder).
//
//   ccc_e      : 3-bit branch condition code encoding
//   state_e    : branch resolution FSM states
//   br_req_t   : a branch request (condition + target) as held while waiting
//   FLUSH_CYCLES, PEND_MAX : flush window length and pending counter ceiling
// -----------------------------------------------------------------------------
package branch_cond_unit_pkg;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned PEND_MAX     = 3;
  localparam int unsigned PEND_W       = 2;
  localparam int unsigned FL_CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    CCC_NEQ    = 3'b000,  // Z=0
    CCC_EQ     = 3'b001,  // Z=1
    CCC_GT     = 3'b010,  // Z=0 & N=0
    CCC_LT     = 3'b011,  // N=1
    CCC_GTE    = 3'b100,  // Z=1 | (Z=0 & N=0)
    CCC_LTE    = 3'b101,  // N=1 | Z=1
    CCC_OVFL   = 3'b110,  // V=1
    CCC_UNCOND = 3'b111   // always
  } ccc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    ccc_e              ccc;
    logic [ADDR_W-1:0] target;
  } br_req_t;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
//   Pure combinational branch condition evaluator. Kept as its own module so
//   the decoder can reuse exactly the same condition semantics.
//
//   ccc    in  : condition code
//   n/z/v  in  : flag values
//   taken  out : condition satisfied
// -----------------------------------------------------------------------------
module cond_eval
  import branch_cond_unit_pkg::*;
(
  input  ccc_e ccc,
  input  logic n_flag,
  input  logic z_flag,
  input  logic v_flag,
  output logic taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CCC_NEQ:    taken = ~z_flag;
      CCC_EQ:     taken =  z_flag;
      CCC_GT:     taken = ~z_flag & ~n_flag;
      CCC_LT:     taken =  n_flag;
      CCC_GTE:    taken =  z_flag | (~z_flag & ~n_flag);
      CCC_LTE:    taken =  n_flag | z_flag;
      CCC_OVFL:   taken =  v_flag;
      CCC_UNCOND: taken =  1'b1;
      default:    taken =  1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
//   Resolves conditional branches against the flag register. A branch can only
//   be resolved once no flag-setting instruction is in flight; until then the
//   branch is latched and upstream is stalled. A taken branch produces a
//   one-cycle redirect pulse followed by a FLUSH_CYCLES-long flush/stall window.
//
//   clk, rst              : clock, async active-high reset
//   br_valid/ccc/target   : branch presented by upstream (ignored while stall)
//   flag_wr_issue/done    : flag writer entering the pipe / writing flags
//   N_flag, Z_flag, V_flag: live flag register values
//   stall                 : upstream must hold its branch
//   redirect_valid/pc     : one-cycle redirect pulse and target
//   flush                 : squash younger instructions
//   pend_err              : sticky pending-counter over/underflow
// -----------------------------------------------------------------------------
module branch_cond_unit
  import branch_cond_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [2:0]        br_ccc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flag_wr_issue,
  input  logic              flag_wr_done,
  input  logic              N_flag,
  input  logic              Z_flag,
  input  logic              V_flag,
  output logic              stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              pend_err
);

  state_e              state_q, state_d;
  br_req_t             lat_q, lat_d;
  br_req_t             cur_req, eval_req;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                pend_err_q, pend_err_d;
  logic [FL_CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic                redir_q, redir_d;
  logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;
  logic                pend_zero;
  logic                eval_taken;

  // ---------------------------------------------------------------------------
  // Condition evaluation. In WAIT the latched condition is used, otherwise the
  // one on the input. Flags are always the live ones: resolution only happens
  // when nothing is pending, so the live flags are the architectural ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_req        = '0;
    cur_req.ccc    = ccc_e'(br_ccc);
    cur_req.target = br_target;
  end

  assign eval_req  = (state_q == ST_WAIT) ? lat_q : cur_req;
  assign pend_zero = (pend_q == '0);

  cond_eval u_cond_eval (
    .ccc    (eval_req.ccc),
    .n_flag (N_flag),
    .z_flag (Z_flag),
    .v_flag (V_flag),
    .taken  (eval_taken)
  );

  // ---------------------------------------------------------------------------
  // Pending flag-writer counter. Runs every cycle regardless of FSM state.
  // Saturates at PEND_MAX and floors at 0; either clamp raises the sticky error.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d     = pend_q;
    pend_err_d = pend_err_q;
    case ({flag_wr_issue, flag_wr_done})
      2'b10: begin
        if (pend_q == PEND_W'(PEND_MAX)) pend_err_d = 1'b1;
        else                             pend_d     = pend_q + PEND_W'(1);
      end
      2'b01: begin
        if (pend_zero) pend_err_d = 1'b1;
        else           pend_d     = pend_q - PEND_W'(1);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch FSM. Decisions use the registered counter, so a done arriving in the
  // same cycle as a branch still forces WAIT; resolution happens the cycle after
  // the counter has actually reached zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    fl_cnt_d   = fl_cnt_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          if (pend_zero) begin
            if (eval_taken) begin
              state_d    = ST_FLUSH;
              redir_d    = 1'b1;
              redir_pc_d = cur_req.target;
              fl_cnt_d   = FL_CNT_W'(FLUSH_CYCLES - 1);
            end
          end else begin
            state_d = ST_WAIT;
            lat_d   = cur_req;
          end
        end
      end
      ST_WAIT: begin
        if (pend_zero) begin
          if (eval_taken) begin
            state_d    = ST_FLUSH;
            redir_d    = 1'b1;
            redir_pc_d = lat_q.target;
            fl_cnt_d   = FL_CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        // First FLUSH cycle coincides with the redirect pulse.
        if (fl_cnt_q == '0) state_d  = ST_IDLE;
        else                fl_cnt_d = fl_cnt_q - FL_CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      pend_q     <= '0;
      pend_err_q <= 1'b0;
      fl_cnt_q   <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
      fl_cnt_q   <= fl_cnt_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign stall          = (state_q != ST_IDLE);
  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  assign pend_err       = pend_err_q;

endmodule
